// File: rtl/axi_w_checker.sv
// Passive AXI W-channel protocol checker: burst length, last placement, stall stability, null strobes.
// Latency: err_pulse, burst_done and counters are registered, visible one cycle after the causing edge.
// Backpressure: none exerted; the W channel is observe-only, exp_ready is high whenever no descriptor is held.
module axi_w_checker #(
    parameter int DATA_W          = 32,
    parameter int STRB_W          = DATA_W / 8,
    parameter int LEN_W           = 8,
    parameter int CNT_W           = 16,
    parameter bit ALLOW_NULL_STRB = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_valid,
    input  logic [LEN_W-1:0]  exp_len,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic [STRB_W-1:0] w_strb,
    input  logic              w_last,
    input  logic              w_valid,
    input  logic              w_ready,
    input  logic              clr,
    output logic [5:0]        err_pulse,
    output logic [5:0]        err_sticky,
    output logic              burst_done,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]  burst_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] TRANS = 2'd2;

    // Error bit positions
    localparam int E_VALID_DROP   = 0;
    localparam int E_DATA_UNSTAB  = 1;
    localparam int E_LAST_EARLY   = 2;
    localparam int E_LAST_MISSING = 3;
    localparam int E_NO_BURST     = 4;
    localparam int E_NULL_STRB    = 5;

    logic [1:0]        state, state_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [LEN_W-1:0]  idx, idx_nxt;
    logic              stall_vld;
    logic [DATA_W-1:0] stall_data;
    logic [STRB_W-1:0] stall_strb;
    logic              stall_last;
    logic              beat;
    logic              stall;
    logic              done_nxt;
    logic [5:0]        err_nxt;

    assign beat      = w_valid & w_ready;
    assign stall     = w_valid & ~w_ready;
    assign exp_ready = (state == IDLE);

    // Classify this cycle's W activity and compute the next burst-tracking state
    always_comb begin
        err_nxt   = '0;
        done_nxt  = 1'b0;
        state_nxt = state;
        len_nxt   = len_q;
        idx_nxt   = idx;

        // A stalled beat must be presented again unchanged until accepted
        if (stall_vld) begin
            if (!w_valid) begin
                err_nxt[E_VALID_DROP] = 1'b1;
            end else if ((w_data != stall_data) || (w_strb != stall_strb) ||
                         (w_last != stall_last)) begin
                err_nxt[E_DATA_UNSTAB] = 1'b1;
            end
        end

        if (beat && !ALLOW_NULL_STRB && (w_strb == '0)) begin
            err_nxt[E_NULL_STRB] = 1'b1;
        end

        if (state == IDLE) begin
            // A beat without a descriptor is flagged; it does not start a burst
            if (beat) begin
                err_nxt[E_NO_BURST] = 1'b1;
            end
            if (exp_valid) begin
                state_nxt = ARMED;
                len_nxt   = exp_len;
                idx_nxt   = '0;
            end
        end else if (beat) begin
            if (idx == len_q) begin
                // Final expected beat: burst ends whether or not last was marked
                err_nxt[E_LAST_MISSING] = ~w_last;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end else if (w_last) begin
                err_nxt[E_LAST_EARLY] = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end else begin
                idx_nxt   = idx + 1'b1;
                state_nxt = TRANS;
            end
        end
    end

    // Burst tracking state and the copy of the most recent stalled beat
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            len_q      <= '0;
            idx        <= '0;
            stall_vld  <= 1'b0;
            stall_data <= '0;
            stall_strb <= '0;
            stall_last <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            idx       <= idx_nxt;
            stall_vld <= stall;
            if (stall) begin
                stall_data <= w_data;
                stall_strb <= w_strb;
                stall_last <= w_last;
            end
        end
    end

    // Registered error/completion outputs; clr wins over a same-cycle new error
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_pulse  <= '0;
            err_sticky <= '0;
            burst_done <= 1'b0;
        end else begin
            err_pulse  <= err_nxt;
            burst_done <= done_nxt;
            err_sticky <= clr ? 6'd0 : (err_sticky | err_nxt);
        end
    end

    // Saturating beat and burst counters
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            beat_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            if (beat && (beat_cnt != '1)) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (done_nxt && (burst_cnt != '1)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_w_checker.sv
// Testbench for axi_w_checker: directed scenarios then randomized traffic against a reference model.
// Outputs are compared every cycle, 1 time unit after the rising edge.
// Counters use a narrow width so saturation is reached within the run.
module tb_axi_w_checker;

    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        exp_valid;
    logic [7:0]  exp_len;
    logic        exp_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic        clr;
    logic [5:0]  err_pulse;
    logic [5:0]  err_sticky;
    logic        burst_done;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] burst_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_w_checker #(
        .DATA_W(32), .LEN_W(8), .CNT_W(CNT_W), .ALLOW_NULL_STRB(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .exp_valid(exp_valid), .exp_len(exp_len),
        .exp_ready(exp_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready), .clr(clr), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .burst_done(burst_done), .beat_cnt(beat_cnt),
        .burst_cnt(burst_cnt)
    );

    // Reference model: a held descriptor is "beats remaining"; a stall is a saved tuple.
    bit          m_busy;
    int          m_left;
    bit          m_sv;
    logic [31:0] m_sd;
    logic [3:0]  m_ss;
    bit          m_sl;
    logic [5:0]  m_pulse;
    logic [5:0]  m_sticky;
    bit          m_done;
    int          m_beats;
    int          m_bursts;

    task automatic model_step();
        logic [5:0] e;
        bit d;
        bit b;
        if (!reset) begin
            m_busy = 0; m_left = 0; m_sv = 0; m_pulse = '0; m_sticky = '0;
            m_done = 0; m_beats = 0; m_bursts = 0;
        end else begin
            e = '0; d = 0;
            b = w_valid && w_ready;
            if (m_sv) begin
                if (!w_valid) e[0] = 1'b1;
                else if (w_data !== m_sd || w_strb !== m_ss || w_last !== m_sl) e[1] = 1'b1;
            end
            if (b && w_strb == 4'h0) e[5] = 1'b1;
            if (!m_busy) begin
                if (b) e[4] = 1'b1;
                if (exp_valid) begin
                    m_busy = 1;
                    m_left = int'(exp_len) + 1;
                end
            end else if (b) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (!w_last) e[3] = 1'b1;
                    d = 1; m_busy = 0;
                end else if (w_last) begin
                    e[2] = 1'b1;
                    d = 1; m_busy = 0;
                end
            end
            m_sv = w_valid && !w_ready;
            if (m_sv) begin
                m_sd = w_data; m_ss = w_strb; m_sl = w_last;
            end
            m_pulse = e;
            m_done  = d;
            if (clr) begin
                m_sticky = '0; m_beats = 0; m_bursts = 0;
            end else begin
                m_sticky = m_sticky | e;
                if (b && m_beats < CMAX) m_beats++;
                if (d && m_bursts < CMAX) m_bursts++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: advance model with the current inputs, then compare every output
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("exp_ready",  32'(exp_ready),  32'(!m_busy));
        chk("err_pulse",  32'(err_pulse),  32'(m_pulse));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        chk("burst_done", 32'(burst_done), 32'(m_done));
        chk("beat_cnt",   32'(beat_cnt),   32'(m_beats));
        chk("burst_cnt",  32'(burst_cnt),  32'(m_bursts));
    endtask

    task automatic drv(input bit v, input bit r, input logic [31:0] d, input logic [3:0] s, input bit l);
        w_valid = v; w_ready = r; w_data = d; w_strb = s; w_last = l;
    endtask

    bit          prev_stall;
    logic [31:0] rd;

    initial begin
        reset = 1'b0; exp_valid = 1'b0; exp_len = '0; clr = 1'b0;
        drv(0, 0, 32'h0, 4'hF, 0);
        tick(); tick();
        chk("rst_err_pulse", 32'(err_pulse), 32'h0);
        chk("rst_exp_ready", 32'(exp_ready), 32'h1);
        chk("rst_beat_cnt",  32'(beat_cnt),  32'h0);
        reset = 1'b1;
        tick();

        // Four-beat burst, last on the fourth beat
        exp_valid = 1; exp_len = 8'd3; tick(); exp_valid = 0;
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, $urandom, 4'hF, i == 3);
            tick();
        end
        drv(0, 0, 32'h0, 4'hF, 0); tick();
        chk("b4_burst_cnt", 32'(burst_cnt), 32'd1);
        chk("b4_beat_cnt",  32'(beat_cnt),  32'd4);
        chk("b4_sticky",    32'(err_sticky), 32'd0);

        // Early last on beat 2 of 4
        clr = 1; tick(); clr = 0;
        exp_valid = 1; exp_len = 8'd3; tick(); exp_valid = 0;
        drv(1, 1, 32'h11, 4'hF, 0); tick();
        drv(1, 1, 32'h22, 4'hF, 1); tick();
        chk("early_pulse", 32'(err_pulse), 32'h04);
        chk("early_done",  32'(burst_done), 32'h1);
        chk("early_ready", 32'(exp_ready), 32'h1);
        drv(0, 0, 32'h0, 4'hF, 0); tick();
        chk("early_one_cycle", 32'(err_pulse), 32'h0);

        // Missing last on a two-beat burst
        exp_valid = 1; exp_len = 8'd1; tick(); exp_valid = 0;
        drv(1, 1, 32'h33, 4'hF, 0); tick();
        drv(1, 1, 32'h44, 4'hF, 0); tick();
        chk("miss_pulse", 32'(err_pulse), 32'h08);
        chk("miss_done",  32'(burst_done), 32'h1);
        drv(0, 0, 32'h0, 4'hF, 0); tick();

        // Data changed during a stall, then valid dropped during a stall
        drv(1, 0, 32'hA5A5A5A5, 4'hF, 0); tick();
        drv(1, 0, 32'h5A5A5A5A, 4'hF, 0); tick();
        chk("unstable_pulse", 32'(err_pulse), 32'h02);
        drv(0, 0, 32'h5A5A5A5A, 4'hF, 0); tick();
        chk("drop_pulse", 32'(err_pulse), 32'h01);
        tick();

        // Beat with no descriptor, then clear
        clr = 1; tick(); clr = 0;
        drv(1, 1, 32'h55, 4'hF, 1); tick();
        chk("nob_pulse", 32'(err_pulse), 32'h10);
        chk("nob_beats", 32'(beat_cnt), 32'd1);
        chk("nob_bursts", 32'(burst_cnt), 32'd0);
        drv(0, 0, 32'h0, 4'hF, 0); clr = 1; tick(); clr = 0;
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        chk("clr_beats",  32'(beat_cnt), 32'd0);

        // Reset mid-burst, stall during reset, then a clean single-beat burst
        exp_valid = 1; exp_len = 8'd7; tick(); exp_valid = 0;
        drv(1, 1, 32'h66, 4'hF, 0); tick();
        drv(1, 1, 32'h77, 4'hF, 0); tick();
        reset = 0; drv(1, 0, 32'h88, 4'hF, 0); tick();
        chk("mid_rst_done",  32'(burst_done), 32'h0);
        chk("mid_rst_pulse", 32'(err_pulse), 32'h0);
        chk("mid_rst_ready", 32'(exp_ready), 32'h1);
        reset = 1; drv(0, 0, 32'h0, 4'hF, 0); tick();
        chk("post_rst_pulse", 32'(err_pulse), 32'h0);
        exp_valid = 1; exp_len = 8'd0; tick(); exp_valid = 0;
        drv(1, 1, 32'h99, 4'hF, 1); tick();
        chk("len0_done",   32'(burst_done), 32'h1);
        chk("len0_pulse",  32'(err_pulse), 32'h0);
        chk("len0_bursts", 32'(burst_cnt), 32'd1);

        // Null strobe on an accepted final beat
        exp_valid = 1; exp_len = 8'd0; tick(); exp_valid = 0;
        drv(1, 1, 32'hAB, 4'h0, 1); tick();
        chk("null_pulse", 32'(err_pulse), 32'h20);
        chk("null_done",  32'(burst_done), 32'h1);
        drv(0, 0, 32'h0, 4'hF, 0); tick();

        // Randomized traffic: first without clr/reset to reach saturation
        for (int i = 0; i < 1200; i++) begin
            prev_stall = w_valid && !w_ready;
            reset = (i < 300) ? 1'b1 : ($urandom_range(0, 149) != 0);
            clr   = (i < 300) ? 1'b0 : ($urandom_range(0, 79) == 0);
            exp_valid = ($urandom_range(0, 2) == 0);
            exp_len   = 8'($urandom_range(0, 3));
            if (prev_stall && $urandom_range(0, 4) != 0) begin
                w_valid = 1'b1;
            end else begin
                rd = $urandom;
                drv($urandom_range(0, 3) != 0, 0, rd,
                    ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    $urandom_range(0, 3) == 0);
            end
            w_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (i == 299) chk("beat_saturated", 32'(beat_cnt), 32'(CMAX));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_w_checker.md
AXI_W_CHECKER -- requirements
Module: axi_w_checker

Interface
REQ-001 Parameter DATA_W, default 32, W data width in bits; legal values 32, 64, 128.
REQ-002 Parameter STRB_W, default DATA_W/8, strobe width; not overridden independently.
REQ-003 Parameter LEN_W, default 8, width of the expected-burst-length field.
REQ-004 Parameter CNT_W, default 16, width of the beat and burst counters.
REQ-005 Parameter ALLOW_NULL_STRB, default 1; 0 makes an all-zero strobe on an accepted beat an error.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 exp_valid  in  1  expected-burst descriptor valid.
REQ-009 exp_len  in  LEN_W  expected beats minus 1.
REQ-010 exp_ready  out  1  checker can accept a descriptor.
REQ-011 w_data, w_strb, w_last, w_valid, w_ready  in  DATA_W, STRB_W, 1, 1, 1  monitored W channel; observe only.
REQ-012 clr  in  1  clears err_sticky and both counters.
REQ-013 err_pulse  out  6  per-cycle error flags; bit map in REQ-020.
REQ-014 err_sticky  out  6  accumulated error flags.
REQ-015 burst_done  out  1  one-cycle pulse when a burst terminates.
REQ-016 beat_cnt, burst_cnt  out  CNT_W each  accepted beats and completed bursts.

Function
REQ-017 Beat = cycle with w_valid & w_ready high at rising clk.
REQ-018 States: IDLE (no descriptor), ARMED (descriptor held, no beat yet), TRANS (at least one beat of current burst accepted).
REQ-019 exp_ready = 1 only in IDLE; descriptor captured on exp_valid & exp_ready; IDLE -> ARMED; beat index cleared to 0.
REQ-020 err bits: [0] valid_drop, [1] data_unstable, [2] last_early, [3] last_missing, [4] no_burst, [5] null_strb.
REQ-021 Beat in IDLE: err_pulse[4] set; beat counted in beat_cnt; state unchanged.
REQ-022 Beat in ARMED or TRANS with index < exp_len: w_last=0 -> index+1, state TRANS; w_last=1 -> err_pulse[2], burst_done, state IDLE.
REQ-023 Beat with index == exp_len: w_last=0 -> err_pulse[3]; in all cases burst_done, state IDLE.
REQ-024 exp_len = 0: first beat is final; ARMED -> IDLE directly.
REQ-025 Stall = w_valid & !w_ready; checker registers w_data, w_strb, w_last at each stall.
REQ-026 Cycle following a stall with w_valid=0: err_pulse[0].
REQ-027 Cycle following a stall with w_valid=1 and any of data/strb/last differing from registered copy: err_pulse[1].
REQ-028 ALLOW_NULL_STRB=0 and beat with w_strb all zero: err_pulse[5]; burst tracking unaffected.
REQ-029 Stability checks (REQ-026/027) apply in every state, including IDLE.
REQ-030 Latency: err_pulse, burst_done and counter updates registered, visible the cycle after the offending/terminating edge; err_pulse bits high exactly one cycle per event.
REQ-031 Multiple errors in one cycle: all corresponding err_pulse bits set together.
REQ-032 err_sticky bit = OR of its err_pulse history since last reset/clr; clr has priority over a same-cycle new error (cleared, new error lost).
REQ-033 beat_cnt +1 per beat; burst_cnt +1 per burst_done; both saturate at all-ones, no wrap.
REQ-034 clr same cycle as beat: counters read 0 next cycle.
REQ-035 Checker drives no W channel signal; it never alters DUT handshake.

Reset
REQ-036 reset=0 at rising clk: state IDLE, exp_ready=1 on next cycle, err_pulse=0, err_sticky=0, burst_done=0, beat_cnt=0, burst_cnt=0, stall register invalidated.
REQ-037 Reset mid-burst abandons burst silently: no burst_done, no last_missing.
REQ-038 Beats while reset=0 ignored; first post-reset cycle carries no stability check.

Verification
REQ-039 exp_len=3, four beats, w_last on 4th -> one burst_done, burst_cnt=1, beat_cnt=4, err_sticky=0.
REQ-040 exp_len=3, w_last on beat 2 -> err_pulse[2] one cycle, burst_done, IDLE, exp_ready=1.
REQ-041 exp_len=1, two beats, w_last=0 both -> err_pulse[3] after beat 2, burst_done.
REQ-042 w_valid=1, w_ready=0, next cycle w_data 0xA5A5A5A5 -> 0x5A5A5A5A -> err_pulse[1]; next case w_valid dropped -> err_pulse[0].
REQ-043 Beat with no descriptor -> err_pulse[4], beat_cnt=1, burst_cnt=0; then clr -> err_sticky=0, counters 0.
REQ-044 reset=0 after beat 2 of exp_len=7 burst -> all outputs reset, no burst_done; new exp_len=0 burst, single beat with w_last -> clean completion.
